// File: rtl/sbox_scheduler_pkg.sv
// sbox_scheduler_pkg: shared types, key byte order and xtime for the masked S-box scheduler
package sbox_scheduler_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, ROUND_END, DONE} state_t;
  typedef struct packed {
    logic       valid;
    logic       key;
    logic [3:0] idx;
  } tag_t;
  localparam int ITEMS = 20;
  localparam int KEY_ITEMS = 4;
  localparam logic [3:0] KEY_IDX [KEY_ITEMS] = '{4'd13, 4'd14, 4'd15, 4'd12};
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/sbox_scheduler_tag_pipe.sv
// sbox_tag_pipe: delays issue tags by the S-box latency so each result carries its own tag
module sbox_tag_pipe import sbox_scheduler_pkg::*; #(
  parameter int SBOX_LAT = 5
) (
  input  logic clk,
  input  logic rst,
  input  tag_t d,
  output tag_t q
);
  tag_t sr [SBOX_LAT];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SBOX_LAT; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < SBOX_LAT; i++) sr[i] <= sr[i-1];
    end
  end
  assign q = sr[SBOX_LAT-1];
endmodule

// File: rtl/sbox_scheduler.sv
// sbox_scheduler: sequences key-schedule and state bytes of each AES round through one shared S-box
module sbox_scheduler import sbox_scheduler_pkg::*; #(
  parameter int SBOX_LAT   = 5,
  parameter int NUM_ROUNDS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rnd_valid,
  output logic       busy,
  output logic       issue_valid,
  output logic       issue_key,
  output logic [3:0] issue_idx,
  output logic       rnd_ack,
  output logic       wb_valid,
  output logic       wb_key,
  output logic [3:0] wb_idx,
  output logic       round_done,
  output logic       final_round,
  output logic [7:0] rcon,
  output logic       done
);
  localparam int RW = $clog2(NUM_ROUNDS + 1);
  state_t        state;
  logic [4:0]    cnt;
  logic [RW-1:0] round;
  logic          last_round;
  tag_t          wb_tag;
  assign last_round  = round == RW'(NUM_ROUNDS);
  assign issue_valid = state == ISSUE && rnd_valid;
  assign issue_key   = issue_valid && cnt < 5'(KEY_ITEMS);
  assign issue_idx   = !issue_valid ? 4'd0 : issue_key ? KEY_IDX[cnt[1:0]] : 4'(cnt - 5'(KEY_ITEMS));
  assign rnd_ack     = issue_valid;
  assign busy        = state == ISSUE || state == DRAIN || state == ROUND_END;
  assign round_done  = state == ROUND_END;
  assign final_round = busy && last_round;
  assign done        = state == DONE;
  assign wb_valid    = wb_tag.valid;
  assign wb_key      = wb_tag.key;
  assign wb_idx      = wb_tag.idx;
  // cnt counts issued items in ISSUE and elapsed drain cycles in DRAIN
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      round <= '0;
      rcon  <= 8'h01;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state <= ISSUE;
          round <= RW'(1);
          rcon  <= 8'h01;
          cnt   <= '0;
        end
        ISSUE: if (rnd_valid) begin
          cnt   <= cnt == 5'(ITEMS - 1) ? 5'd0 : cnt + 5'd1;
          state <= cnt == 5'(ITEMS - 1) ? DRAIN : ISSUE;
        end
        DRAIN: begin
          cnt   <= cnt == 5'(SBOX_LAT - 1) ? 5'd0 : cnt + 5'd1;
          state <= cnt == 5'(SBOX_LAT - 1) ? ROUND_END : DRAIN;
        end
        ROUND_END: begin
          cnt   <= '0;
          state <= last_round ? DONE : ISSUE;
          round <= last_round ? round : round + RW'(1);
          rcon  <= last_round ? rcon : xtime(rcon);
        end
        default: state <= IDLE;
      endcase
    end
  end
  sbox_tag_pipe #(.SBOX_LAT(SBOX_LAT)) u_pipe (
    .clk (clk),
    .rst (rst),
    .d   ('{valid: issue_valid, key: issue_key, idx: issue_idx}),
    .q   (wb_tag)
  );
endmodule

// File: tb/tb_sbox_scheduler.sv
// tb_sbox_scheduler: scoreboard bench driving SBOX_LAT=5 and SBOX_LAT=1 schedulers with shared stimulus
module tb_sbox_scheduler;
  localparam int NU = 2;
  localparam int LAT [NU] = '{5, 1};
  localparam int NR = 10;
  localparam int BIG = 1 << 30;
  localparam int RVN = 2048;
  localparam logic [7:0] RCON [NR] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  typedef struct {int cyc; logic key; logic [3:0] idx;} ev_t;
  typedef struct {int cyc; logic [7:0] rcon; logic fin;} rd_t;

  logic clk = 0, rst = 1, start = 0, rnd_valid = 0;
  logic busy [NU], iv [NU], ik [NU], ack [NU], wv [NU], wk [NU], rdn [NU], fin [NU], dn [NU];
  logic [3:0] ii [NU], wi [NU];
  logic [7:0] rc [NU];

  for (genvar g = 0; g < NU; g++) begin : g_dut
    sbox_scheduler #(.SBOX_LAT(g == 0 ? 5 : 1), .NUM_ROUNDS(NR)) dut (
      .clk(clk), .rst(rst), .start(start), .rnd_valid(rnd_valid),
      .busy(busy[g]), .issue_valid(iv[g]), .issue_key(ik[g]), .issue_idx(ii[g]),
      .rnd_ack(ack[g]), .wb_valid(wv[g]), .wb_key(wk[g]), .wb_idx(wi[g]),
      .round_done(rdn[g]), .final_round(fin[g]), .rcon(rc[g]), .done(dn[g])
    );
  end

  ev_t iq [NU][$];
  ev_t wq [NU][$];
  rd_t rq [NU][$];
  int busy_lo [NU], busy_hi [NU], done_lo [NU], done_hi [NU], fin_lo [NU], fin_hi [NU];
  int rd_at [NU][NR];
  int idle_lo = 0, idle_hi = BIG, e_run = BIG;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  bit rv [RVN];
  bit chk = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk1(input string name, input int u, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s lat%0d cyc %0d: got %b want %b", name, LAT[u], cyc, act, exp);
    end
  endfunction

  function automatic void chkv(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s lat%0d cyc %0d: got %0h want %0h", name, LAT[u], cyc, act, exp);
    end
  endfunction

  function automatic logic [3:0] idx_of(input int n);
    return 4'(n < 4 ? (n == 3 ? 12 : 13 + n) : n - 4);
  endfunction

  // Expected timeline of a whole run: each round takes the next 20 cycles with randomness,
  // then drains for the latency and spends one cycle on the round end.
  task automatic plan(input int e);
    for (int u = 0; u < NU; u++) begin
      int k = 0;
      for (int r = 0; r < NR; r++) begin
        int n = 0;
        rd_t y;
        if (r == NR - 1) fin_lo[u] = e + k;
        while (n < 20) begin
          if (rv[k]) begin
            ev_t x;
            x.cyc = e + k; x.key = n < 4; x.idx = idx_of(n);
            iq[u].push_back(x);
            x.cyc = e + k + LAT[u];
            wq[u].push_back(x);
            n++;
          end
          k++;
        end
        y.cyc = e + k + LAT[u]; y.rcon = RCON[r]; y.fin = r == NR - 1;
        rq[u].push_back(y);
        rd_at[u][r] = y.cyc;
        k += LAT[u] + 1;
      end
      busy_lo[u] = e; busy_hi[u] = e + k;
      done_lo[u] = e + k; done_hi[u] = BIG;
      fin_hi[u] = e + k;
    end
    idle_hi = idle_hi > e ? e : idle_hi;
  endtask

  task automatic reset_model(input int c);
    for (int u = 0; u < NU; u++) begin
      while (iq[u].size() > 0 && iq[u][$].cyc > c) void'(iq[u].pop_back());
      while (wq[u].size() > 0 && wq[u][$].cyc > c) void'(wq[u].pop_back());
      while (rq[u].size() > 0 && rq[u][$].cyc > c) void'(rq[u].pop_back());
      busy_hi[u] = busy_hi[u] > c + 1 ? c + 1 : busy_hi[u];
      done_hi[u] = done_hi[u] > c + 1 ? c + 1 : done_hi[u];
      fin_hi[u]  = fin_hi[u]  > c + 1 ? c + 1 : fin_hi[u];
    end
    idle_lo = c + 1; idle_hi = BIG;
  endtask

  always @(negedge clk) if (chk) for (int u = 0; u < NU; u++) begin
    ev_t x;
    rd_t y;
    bit due;
    while (iq[u].size() > 0 && iq[u][0].cyc < cyc) void'(iq[u].pop_front());
    due = iq[u].size() > 0 && iq[u][0].cyc == cyc;
    chk1("issue_valid", u, iv[u], due);
    chk1("rnd_ack", u, ack[u], due);
    if (iv[u] === 1'b1 && iq[u].size() > 0) begin
      x = iq[u].pop_front();
      chkv("issue_cyc", u, cyc, x.cyc);
      chkv("issue_tag", u, {27'd0, ik[u], ii[u]}, {27'd0, x.key, x.idx});
    end else if (iv[u] !== 1'b1) chkv("issue_zero", u, {27'd0, ik[u], ii[u]}, 32'd0);
    while (wq[u].size() > 0 && wq[u][0].cyc < cyc) void'(wq[u].pop_front());
    due = wq[u].size() > 0 && wq[u][0].cyc == cyc;
    chk1("wb_valid", u, wv[u], due);
    if (wv[u] === 1'b1 && wq[u].size() > 0) begin
      x = wq[u].pop_front();
      chkv("wb_cyc", u, cyc, x.cyc);
      chkv("wb_tag", u, {27'd0, wk[u], wi[u]}, {27'd0, x.key, x.idx});
    end else if (wv[u] !== 1'b1) chkv("wb_zero", u, {27'd0, wk[u], wi[u]}, 32'd0);
    while (rq[u].size() > 0 && rq[u][0].cyc < cyc) void'(rq[u].pop_front());
    due = rq[u].size() > 0 && rq[u][0].cyc == cyc;
    chk1("round_done", u, rdn[u], due);
    if (rdn[u] === 1'b1 && rq[u].size() > 0) begin
      y = rq[u].pop_front();
      chkv("round_cyc", u, cyc, y.cyc);
      chkv("rcon", u, {24'd0, rc[u]}, {24'd0, y.rcon});
      chk1("final_at_end", u, fin[u], y.fin);
    end
    chk1("busy", u, busy[u], cyc >= busy_lo[u] && cyc < busy_hi[u]);
    chk1("done", u, dn[u], cyc >= done_lo[u] && cyc < done_hi[u]);
    chk1("final_round", u, fin[u], cyc >= fin_lo[u] && cyc < fin_hi[u]);
    if (cyc >= idle_lo && cyc < idle_hi) chkv("rcon_reset", u, {24'd0, rc[u]}, 32'h01);
    if (cyc >= done_lo[u] && cyc < done_hi[u]) chkv("rcon_hold", u, {24'd0, rc[u]}, {24'd0, RCON[NR-1]});
  end

  task automatic tick();
    @(posedge clk); #1;
    rnd_valid = (cyc >= e_run && cyc - e_run < RVN) ? rv[cyc - e_run] : 1'($urandom);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) tick();
  endtask

  task automatic launch();
    start = 1;
    e_run = cyc + 1;
    tick();
    start = 0;
    plan(e_run);
  endtask

  function automatic int run_end();
    return (done_lo[0] > done_lo[1] ? done_lo[0] : done_lo[1]) + 3;
  endfunction

  initial begin
    for (int u = 0; u < NU; u++) begin
      busy_lo[u] = 0; busy_hi[u] = 0; done_lo[u] = 0; done_hi[u] = 0; fin_lo[u] = 0; fin_hi[u] = 0;
    end
    tick();
    chk = 1;
    tick(); tick();
    rst = 0;
    repeat (3) tick();
    // uninterrupted randomness, plus a start pulse during a round end that must be ignored
    for (int k = 0; k < RVN; k++) rv[k] = 1'b1;
    launch();
    wait_until(rd_at[0][1]);
    start = 1;
    tick();
    start = 0;
    wait_until(run_end());
    // restart from DONE with a three-cycle randomness gap at item 7
    rv[7] = 1'b0; rv[8] = 1'b0; rv[9] = 1'b0;
    launch();
    wait_until(run_end());
    // random randomness, reset in the middle of the round-4 drain
    for (int k = 0; k < RVN; k++) rv[k] = $urandom_range(3) != 0;
    launch();
    wait_until(rd_at[0][3] - 3);
    rst = 1;
    reset_model(cyc);
    tick();
    rst = 0;
    repeat (40) tick();
    // fresh start after the reset with new random randomness
    for (int k = 0; k < RVN; k++) rv[k] = $urandom_range(4) != 0;
    launch();
    wait_until(run_end());
    for (int u = 0; u < NU; u++) chkv("leftover", u, iq[u].size() + wq[u].size() + rq[u].size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
